// File: rtl/sad_block_min_search.sv
`default_nettype none
// ============================================================================
// Module   : sad_block_min_search
// Purpose  : Accumulates row sums from the 8-input adder tree into per-block
//            SAD values, one block per candidate position. Tracks the minimum
//            block SAD over a search window and reports the winning candidate
//            index (earliest candidate wins ties).
// Ports    : clk         - clock, rising edge
//            rst_n       - synchronous reset, active low
//            start       - begin a new search (honoured only when idle)
//            row_sum     - unsigned row sum from the adder tree
//            in_valid    - row_sum valid
//            in_ready    - row_sum accepted this cycle (high only in ACCUM)
//            best_sad    - minimum block SAD of the completed search
//            best_index  - 0-based arrival index of the best candidate
//            out_valid   - result valid (held until accepted)
//            out_ready   - consumer accepts result
//            busy        - search in progress or result pending
// Revision : 1.0 - initial release
// ============================================================================
module sad_block_min_search #(
   parameter int ELEMENT_BIT_DEPTH = 14,
   parameter int ROWS_PER_BLOCK    = 8,
   parameter int CANDIDATES        = 16,
   parameter int INDEX_WIDTH       = 4
) (
   input  logic                                                   clk,
   input  logic                                                   rst_n,
   input  logic                                                   start,
   input  logic [ELEMENT_BIT_DEPTH-1:0]                           row_sum,
   input  logic                                                   in_valid,
   output logic                                                   in_ready,
   output logic [ELEMENT_BIT_DEPTH+$clog2(ROWS_PER_BLOCK)-1:0]    best_sad,
   output logic [INDEX_WIDTH-1:0]                                 best_index,
   output logic                                                   out_valid,
   input  logic                                                   out_ready,
   output logic                                                   busy
);

   localparam int SAD_WIDTH     = ELEMENT_BIT_DEPTH + $clog2(ROWS_PER_BLOCK);
   localparam int ROW_CNT_WIDTH = $clog2(ROWS_PER_BLOCK);

   localparam logic [ROW_CNT_WIDTH-1:0] LAST_ROW  = ROW_CNT_WIDTH'(ROWS_PER_BLOCK - 1);
   localparam logic [INDEX_WIDTH-1:0]   LAST_CAND = INDEX_WIDTH'(CANDIDATES - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACCUM   = 2'd1;
   localparam logic [1:0] ST_COMPARE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   logic [1:0]               state;
   logic [SAD_WIDTH-1:0]     acc;
   logic [ROW_CNT_WIDTH-1:0] row_cnt;
   logic [INDEX_WIDTH-1:0]   cand_cnt;

   // Handshake outputs decode only the registered state, so there is no
   // combinational path from in_valid to in_ready.
   assign in_ready  = (state == ST_ACCUM);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         acc        <= '0;
         row_cnt    <= '0;
         cand_cnt   <= '0;
         best_sad   <= '1;
         best_index <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  acc        <= '0;
                  row_cnt    <= '0;
                  cand_cnt   <= '0;
                  best_sad   <= '1;
                  best_index <= '0;
                  state      <= ST_ACCUM;
               end
            end

            ST_ACCUM: begin
               // in_ready is high throughout ACCUM, so in_valid alone marks a beat.
               if (in_valid) begin
                  acc     <= acc + SAD_WIDTH'(row_sum);
                  row_cnt <= row_cnt + ROW_CNT_WIDTH'(1);
                  if (row_cnt == LAST_ROW) begin
                     state <= ST_COMPARE;
                  end
               end
            end

            ST_COMPARE: begin
               // Strict less-than keeps the earlier candidate on a tie.
               if (acc < best_sad) begin
                  best_sad   <= acc;
                  best_index <= cand_cnt;
               end
               acc     <= '0;
               row_cnt <= '0;
               if (cand_cnt == LAST_CAND) begin
                  state <= ST_DONE;
               end else begin
                  cand_cnt <= cand_cnt + INDEX_WIDTH'(1);
                  state    <= ST_ACCUM;
               end
            end

            ST_DONE: begin
               // A start coinciding with the handshake is deliberately dropped.
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sad_block_min_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_block_min_search
// Purpose  : Randomized scoreboard bench for sad_block_min_search. A driver
//            feeds candidate blocks and pushes the reference result; a
//            monitor pops and compares on every result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sad_block_min_search;

   localparam int EBD = 14;
   localparam int RPB = 8;
   localparam int NC  = 16;
   localparam int IW  = 4;
   localparam int SW  = EBD + $clog2(RPB);
   localparam longint SAD_ONES = (64'd1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [EBD-1:0] row_sum;
   logic          in_valid;
   logic          in_ready;
   logic [SW-1:0] best_sad;
   logic [IW-1:0] best_index;
   logic          out_valid;
   logic          out_ready;
   logic          busy;

   sad_block_min_search #(
      .ELEMENT_BIT_DEPTH (EBD),
      .ROWS_PER_BLOCK    (RPB),
      .CANDIDATES        (NC),
      .INDEX_WIDTH       (IW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .row_sum    (row_sum),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .best_sad   (best_sad),
      .best_index (best_index),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   always @(posedge clk) cyc++;

   int unsigned rows_mem [NC][RPB];
   int unsigned exp_sad_q [$];
   int unsigned exp_idx_q [$];
   int unsigned mon_sad, mon_idx;

   task automatic chk(input string name, input longint act, input longint exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: block SAD is the plain sum of its rows; the winner is the
   // first candidate whose SAD equals the overall minimum.
   task automatic model(output int unsigned s, output int unsigned idx);
      int unsigned sums [NC];
      int unsigned m;
      for (int c = 0; c < NC; c++) begin
         sums[c] = 0;
         for (int r = 0; r < RPB; r++) sums[c] += rows_mem[c][r];
      end
      m = sums[0];
      for (int c = 1; c < NC; c++) if (sums[c] < m) m = sums[c];
      idx = 0;
      for (int c = NC - 1; c >= 0; c--) if (sums[c] == m) idx = c;
      s = m;
   endtask

   // Monitor: one comparison pair per result handshake.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_sad_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_result: got sad %0d index %0d, expected no result",
                     best_sad, best_index);
         end else begin
            mon_sad = exp_sad_q.pop_front();
            mon_idx = exp_idx_q.pop_front();
            chk("result_sad", best_sad, mon_sad);
            chk("result_index", best_index, mon_idx);
         end
      end
   end

   task automatic fill_random(input int unsigned lo, input int unsigned hi);
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < RPB; r++) rows_mem[c][r] = $urandom_range(hi, lo);
   endtask

   task automatic run_search(input bit gaps, input bit hold, input bit noisy,
                             input bit abort, input bit timing);
      int unsigned es, ei;
      int  cnt, s_cyc;
      bit  first, after_last, beat;
      model(es, ei);
      s_cyc = 0;
      @(posedge clk); #1;
      start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      start = noisy ? 1'($urandom) : 1'b0;
      first = 1'b1;
      after_last = 1'b0;
      for (int c = 0; c < NC; c++) begin
         for (int r = 0; r < RPB; r++) begin
            row_sum = EBD'(rows_mem[c][r]);
            cnt = 0;
            beat = 1'b0;
            while (!beat) begin
               in_valid = gaps ? ($urandom_range(3, 0) != 0) : 1'b1;
               if (noisy) start = 1'($urandom);
               @(negedge clk);
               if (first) begin
                  chk("busy_after_start", busy, 1);
                  chk("in_ready_after_start", in_ready, 1);
                  s_cyc = cyc;
                  first = 1'b0;
               end
               if (after_last) begin
                  chk("compare_in_ready", in_ready, 0);
                  after_last = 1'b0;
               end
               beat = in_valid && in_ready;
               @(posedge clk); #1;
               cnt++;
               if (!beat && cnt > 200) begin
                  chk("beat_timeout", 0, 1);
                  in_valid = 1'b0; start = 1'b0;
                  return;
               end
            end
            after_last = (r == RPB - 1);
            if (abort && c == 2 && r == 2) begin
               rst_n = 1'b0;
               in_valid = 1'($urandom);
               start = 1'($urandom);
               @(posedge clk);
               @(posedge clk); #1;
               rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
               @(negedge clk);
               chk("abort_out_valid", out_valid, 0);
               chk("abort_busy", busy, 0);
               chk("abort_in_ready", in_ready, 0);
               chk("abort_best_sad", best_sad, SAD_ONES);
               return;
            end
         end
      end
      in_valid = 1'b0;
      if (noisy) start = 1'b1;
      exp_sad_q.push_back(es);
      exp_idx_q.push_back(ei);
      out_ready = !hold;
      @(negedge clk);
      chk("last_compare_in_ready", in_ready, 0);
      chk("no_early_valid", out_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("out_valid_latency", out_valid, 1);
      if (timing) chk("search_cycles", cyc - s_cyc, NC * (RPB + 1));
      if (hold) begin
         for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sad", best_sad, es);
            chk("hold_index", best_index, ei);
            @(posedge clk); #1;
            if (i == 4) out_ready = 1'b1;
            @(negedge clk);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("result_kept_sad", best_sad, es);
      chk("result_kept_index", best_index, ei);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'($urandom); in_valid = 1'($urandom);
      row_sum = EBD'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #1;
      start = 1'($urandom); in_valid = 1'($urandom);
      row_sum = EBD'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset_in_ready", in_ready, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_best_sad", best_sad, SAD_ONES);
      chk("reset_best_index", best_index, 0);
      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; row_sum = '0; out_ready = 1'b0;

      // Basic: SADs 800, 400, 1600, 400, then larger blocks -> tie keeps index 1.
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < RPB; r++)
            rows_mem[c][r] = (c == 0) ? 100 : (c == 1 || c == 3) ? 50 : (c == 2) ? 200 : 250;
      run_search(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Full scale on every row of every candidate.
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < RPB; r++) rows_mem[c][r] = 16383;
      run_search(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Random data, input gaps, result backpressure.
      for (int k = 0; k < 3; k++) begin
         fill_random(0, 16383);
         run_search(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end

      // Narrow range forces frequent ties.
      fill_random(0, 1);
      run_search(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of candidate 2, then a fresh search.
      fill_random(0, 16383);
      run_search(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      fill_random(50, 16383);
      for (int r = 0; r < RPB; r++) begin
         rows_mem[0][r] = (r == RPB - 1) ? 200 : 100;
         rows_mem[1][r] = (r == RPB - 1) ? 90  : 30;
         rows_mem[2][r] = (r == RPB - 1) ? 140 : 80;
      end
      run_search(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // start toggling during ACCUM/COMPARE/DONE, then a clean search.
      fill_random(0, 16383);
      run_search(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      fill_random(0, 16383);
      run_search(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained", exp_sad_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire
